// File: rtl/gate_sweep_ctrl_if.sv
// Control, status and gate-pin bundle between a host and gate_sweep_ctrl.
// master = host/bench side, slave = the sequencer.
interface gate_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       gate_out;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] result;

    modport master (
        output start, abort, gate_out,
        input  gate_a, gate_b, busy, done, result, pass
    );

    modport slave (
        input  start, abort, gate_out,
        output gate_a, gate_b, busy, done, result, pass
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through {a,b}=00..11, samples its output after SETTLE cycles
// per vector and compares against EXPECT. Optional: GATE_SWEEP_EARLY_STOP_EN ends on first mismatch.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,       // legal 1..15
    parameter logic [3:0]  EXPECT = 4'b1000
) (
    input logic             clk,
    input logic             rst_n,
    gate_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_e     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] result_q;
    logic       pass_q;
    logic       done_q;
    logic       busy_q;
    logic       gate_a_q;
    logic       gate_b_q;

    logic [3:0] result_d;
    logic       stop_d;

    // Result word including the bit sampled this cycle, and whether this sample ends the sweep.
    always_comb begin
        result_d        = result_q;
        result_d[idx_q] = bus.gate_out;
`ifdef GATE_SWEEP_EARLY_STOP_EN
        stop_d = (idx_q == 2'd3) || (bus.gate_out != EXPECT[idx_q]);
`else
        stop_d = (idx_q == 2'd3);
`endif
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            result_q <= 4'd0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q  <= RUN;
                        idx_q    <= 2'd0;
                        cnt_q    <= CNT_LOAD;
                        result_q <= 4'd0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        state_q  <= IDLE;
                        result_q <= 4'd0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Final cycle of the vector: the only point where gate_out is observed.
                        result_q <= result_d;
                        if (stop_d) begin
                            state_q  <= FINISH;
                            pass_q   <= (result_d == EXPECT);
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            gate_a_q <= 1'b0;
                            gate_b_q <= 1'b0;
                        end else begin
                            idx_q                  <= idx_q + 2'd1;
                            {gate_a_q, gate_b_q}   <= idx_q + 2'd1;
                            cnt_q                  <= CNT_LOAD;
                        end
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                    if (bus.abort) begin
                        result_q <= 4'd0;
                        pass_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate_a = gate_a_q;
    assign bus.gate_b = gate_b_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.pass   = pass_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl (SETTLE=2, EXPECT=AND) with an AND/NAND gate model
// on gate_out; inputs driven and outputs sampled on the falling clock edge.
module tb_gate_sweep_ctrl;
    logic clk;
    logic rst_n;
    logic nand_mode;
    logic glitch;
    int   tests_run;
    int   tests_failed;

    gate_sweep_ctrl_if bus ();

    gate_sweep_ctrl #(
        .SETTLE (2),
        .EXPECT (4'b1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test; glitch flips the output to emulate an unsettled node.
    assign bus.gate_out = (nand_mode ? ~(bus.gate_a & bus.gate_b) : (bus.gate_a & bus.gate_b)) ^ glitch;

    // Cycle 0 ends at the accepting edge; checks happen at the falling edge inside cycle c.
    task automatic run_sweep(input string name, input logic [3:0] exp_res, input logic exp_pass,
                             input bit glitch_en);
        logic       exp_busy;
        logic       exp_done;
        logic [1:0] exp_ab;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            glitch    = glitch_en && (c <= 8) && (c % 2 == 1);
            exp_busy  = (c <= 8);
            exp_done  = (c == 9);
            exp_ab    = (c <= 8) ? 2'((c - 1) / 2) : 2'b00;
            tests_run++;
            if (bus.busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, bus.busy, exp_busy);
            end
            tests_run++;
            if (bus.done !== exp_done) begin
                tests_failed++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, c, bus.done, exp_done);
            end
            tests_run++;
            if ({bus.gate_a, bus.gate_b} !== exp_ab) begin
                tests_failed++;
                $display("FAIL %s vector cycle %0d: got %b%b want %b", name, c, bus.gate_a, bus.gate_b, exp_ab);
            end
            if (c >= 9) begin
                tests_run++;
                if (bus.result !== exp_res) begin
                    tests_failed++;
                    $display("FAIL %s result cycle %0d: got %b want %b", name, c, bus.result, exp_res);
                end
                tests_run++;
                if (bus.pass !== exp_pass) begin
                    tests_failed++;
                    $display("FAIL %s pass cycle %0d: got %b want %b", name, c, bus.pass, exp_pass);
                end
            end
        end
        glitch = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset outputs: got busy=%b done=%b a=%b b=%b pass=%b result=%b want all 0",
                     bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and();
        nand_mode = 1'b0;
        run_sweep("and", 4'b1000, 1'b1, 1'b0);
    endtask

    task automatic test_glitch();
        nand_mode = 1'b0;
        run_sweep("glitch", 4'b1000, 1'b1, 1'b1);
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        tests_run++;
        if ({bus.busy, bus.result, bus.pass} !== {1'b0, 4'b1000, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_idle hold: got busy=%b result=%b pass=%b want 0 1000 1",
                     bus.busy, bus.result, bus.pass);
        end
    endtask

`ifdef GATE_SWEEP_EARLY_STOP_EN
    task automatic test_early_stop();
        nand_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            tests_run++;
            if ({bus.busy, bus.done} !== {1'(c <= 2), 1'(c == 3)}) begin
                tests_failed++;
                $display("FAIL early_stop busy/done cycle %0d: got %b%b want %b%b",
                         c, bus.busy, bus.done, 1'(c <= 2), 1'(c == 3));
            end
            if (c == 3) begin
                tests_run++;
                if ({bus.result, bus.pass} !== {4'b0001, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL early_stop result/pass: got %b %b want 0001 0", bus.result, bus.pass);
                end
            end
        end
    endtask
`else
    task automatic test_nand();
        nand_mode = 1'b1;
        run_sweep("nand", 4'b0111, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        nand_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.busy, bus.done} !== {1'((c % 10) >= 1 && (c % 10) <= 8), 1'(c % 10 == 9)}) begin
                tests_failed++;
                $display("FAIL b2b busy/done cycle %0d: got %b%b want %b%b", c, bus.busy, bus.done,
                         1'((c % 10) >= 1 && (c % 10) <= 8), 1'(c % 10 == 9));
            end
            if (c == 11 || c == 13) begin
                tests_run++;
                if ({bus.gate_a, bus.gate_b} !== 2'((c - 11) / 2)) begin
                    tests_failed++;
                    $display("FAIL b2b vector cycle %0d: got %b%b want %b", c, bus.gate_a, bus.gate_b,
                             2'((c - 11) / 2));
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_abort();
        nand_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.result} !== {1'b1, 4'b0001}) begin
            tests_failed++;
            $display("FAIL abort pre: got busy=%b result=%b want 1 0001", bus.busy, bus.result);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result} !== 9'd0) begin
            tests_failed++;
            $display("FAIL abort cycle4: got busy=%b done=%b a=%b b=%b pass=%b result=%b want all 0",
                     bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 5; c <= 20; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                tests_failed++;
                $display("FAIL abort idle cycle %0d: got busy=%b done=%b want 0 0", c, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        nand_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 2; c <= 5; c++) @(negedge clk);
        tests_run++;
        if (bus.result !== 4'b0011) begin
            tests_failed++;
            $display("FAIL rst_mid pre result: got %b want 0011", bus.result);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result} !== 9'd0) begin
            tests_failed++;
            $display("FAIL rst_mid outputs: got busy=%b done=%b a=%b b=%b pass=%b result=%b want all 0",
                     bus.busy, bus.done, bus.gate_a, bus.gate_b, bus.pass, bus.result);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        nand_mode = 1'b0;
        run_sweep("post_reset", 4'b1000, 1'b1, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        nand_mode    = 1'b0;
        glitch       = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;

        test_reset();
        test_and();
        test_glitch();
        test_abort_idle();
`ifdef GATE_SWEEP_EARLY_STOP_EN
        test_early_stop();
`else
        test_nand();
`endif
        test_back_to_back();
        test_abort();
        test_reset_mid_sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exercises a 2-input gate under test (for example the `nand`/`and` gate cells) through its full truth table. It drives the four input combinations in order, waits a programmable settle time per vector, samples the gate output into a 4-bit result word, and compares it with an expected truth table. It sits between the bench or host control logic and the gate datapath, giving one `start`/`done` handshake per sweep.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `EXPECT`, default 4'b1000: expected truth table; bit index = {a,b}. The default is AND.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `abort`  in  1  cancel a sweep in progress; has priority over `start`.
- `gate_a`  out  1  gate input a, registered.
- `gate_b`  out  1  gate input b, registered.
- `gate_out`  in  1  gate output under test.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `result`  out  4  captured truth table; bit k = `gate_out` sampled for {a,b}=k.
- `pass`  out  1  `result == EXPECT`; valid from the `done` cycle onward.

## Operation
- States:
  - IDLE: `busy`=0, `gate_a`/`gate_b`=0.
  - RUN: `busy`=1; holds a 2-bit vector index `idx` and a 4-bit settle counter.
  - FINISH: lasts one cycle, `done`=1.
- IDLE → RUN when `start`=1 and `abort`=0 at an edge:
  - `idx`←0, counter←SETTLE-1.
  - `result`←0, `pass`←0.
  - `{gate_a,gate_b}`←00.
- RUN, counter>0: decrement the counter.
- RUN, counter=0:
  - `result[idx]`←`gate_out`.
  - If `idx`<3: `idx`←idx+1, `{gate_a,gate_b}`←idx+1, counter←SETTLE-1.
  - If `idx`=3: go to FINISH, `pass`←(`result` with the new bit == EXPECT), `{gate_a,gate_b}`←00.
- FINISH → IDLE unconditionally. `start` during FINISH is ignored.
- `start` while in RUN is ignored; no queuing.
- `abort`=1 in RUN or FINISH:
  - Next state is IDLE; no `done` pulse.
  - `result`←0, `pass`←0, gate inputs←00.
  - `abort` in IDLE has no effect.
- `result` and `pass` hold their values after FINISH until the next accepted `start`, `abort` or reset.
- `gate_out` is sampled only on the final cycle of each vector. Any glitch earlier in the settle window is ignored.

## Timing
- Reset value (`rst_n`=0, asynchronous): state IDLE; `gate_a`, `gate_b`, `busy`, `done`, `pass`, `result` all 0.
- Cycle numbering: the edge that accepts `start` ends cycle 0.
  - Vector k is driven in cycles k·SETTLE+1 … (k+1)·SETTLE.
  - `busy`=1 in cycles 1 … 4·SETTLE.
  - `done`=1 only in cycle 4·SETTLE+1. With the default SETTLE=2, that is cycle 9.
- Back-to-back sweeps: the earliest `start` acceptance is in the cycle after `done`.
- Reset during RUN aborts immediately. No `done` pulse is produced.

## Configuration
- `GATE_SWEEP_EARLY_STOP_EN` defined:
  - At each sample, if the sampled bit ≠ `EXPECT[idx]`, go directly to FINISH.
  - In that case `pass`←0, unsampled `result` bits stay 0, and `done` pulses in the following cycle.
- Macro undefined: all four vectors are always applied; latency is fixed at 4·SETTLE+1.

## Test plan
- AND model on `gate_out`, SETTLE=2, start at cycle 0 → vectors 00,01,10,11 in cycles 1-2, 3-4, 5-6, 7-8; `done` in cycle 9; `result`=4'b1000; `pass`=1.
- NAND model (macro undefined) → `result`=4'b0111, `pass`=0, `done` in cycle 9.
- Repeated `start` held high through a sweep → exactly one `done` per 10 cycles. Second sweep's vector 00 begins in cycle 11.
- `abort` asserted in cycle 3 together with `start` → IDLE at cycle 4; `busy`=0, `result`=0, `pass`=0; no `done` pulse ever.
- `rst_n` low during cycle 5 → all outputs 0 immediately; after release, `start` gives a normal 9-cycle sweep.
- `GATE_SWEEP_EARLY_STOP_EN` with NAND model → mismatch sampled at end of cycle 2; `done` in cycle 3; `result`=4'b0001; `pass`=0.
